// File: rtl/rtc_time_set_ctrl.sv
// RTC time-set sequencer: snapshot, edit hour/minute, commit with one modify pulse.
// Optional alarm editing and matching when RTC_TIME_SET_ALARM_EN is defined.
module rtc_time_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int MODIFY_CYCLES  = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [7:0] i_rtc_sec,
    input  logic [7:0] i_rtc_min,
    input  logic [7:0] i_rtc_hour,
    output logic       o_modify,
    output logic [7:0] o_im_min,
    output logic [7:0] o_im_hour,
    output logic [2:0] o_state,
    output logic       o_busy,
    output logic       o_alarm
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EDIT_HOUR = 3'd1,
        S_EDIT_MIN  = 3'd2,
        S_ALM_HOUR  = 3'd3,
        S_ALM_MIN   = 3'd4,
        S_COMMIT    = 3'd5
    } state_t;

    localparam int CMAX = (TIMEOUT_CYCLES > MODIFY_CYCLES) ?
                          TIMEOUT_CYCLES : MODIFY_CYCLES;
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MOD_LAST = CW'(MODIFY_CYCLES - 1);

    // Wrapping increment/decrement; out-of-range values fold back into range.
    function automatic logic [7:0] f_step(
        input logic [7:0] v,
        input logic [7:0] vmax,
        input logic       inc,
        input logic       dec
    );
        logic [7:0] r;
        r = v;
        if (inc) begin
            r = (v >= vmax) ? 8'd0 : v + 8'd1;
        end else if (dec) begin
            r = (v == 8'd0 || v > vmax) ? vmax : v - 8'd1;
        end
        f_step = r;
    endfunction

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_modify;
    logic          r_busy;
    logic [7:0]    r_im_hour;
    logic [7:0]    r_im_min;
    logic [7:0]    w_im_hour_nx;
    logic [7:0]    w_im_min_nx;
    logic          w_inc;
    logic          w_dec;
    logic          w_btn;
    logic          w_tmo;
    logic          w_clr;

`ifdef RTC_TIME_SET_ALARM_EN
    logic [7:0] r_ae_hour;
    logic [7:0] r_ae_min;
    logic [7:0] w_ae_hour_nx;
    logic [7:0] w_ae_min_nx;
    logic [7:0] r_alm_hour;
    logic [7:0] r_alm_min;
    logic       r_armed;
    logic       r_match;
    logic       r_alarm;
    logic       w_match;
    logic       w_commit_entry;
`endif

    assign w_inc = i_btn_up & ~i_btn_down & ~i_btn_mode;
    assign w_dec = i_btn_down & ~i_btn_up & ~i_btn_mode;
    assign w_btn = i_btn_mode | i_btn_up | i_btn_down;
    assign w_tmo = (r_cnt == TMO_LAST) && !w_btn;

    always_comb begin
        w_state_nx   = r_state;
        w_im_hour_nx = r_im_hour;
        w_im_min_nx  = r_im_min;
`ifdef RTC_TIME_SET_ALARM_EN
        w_ae_hour_nx = r_ae_hour;
        w_ae_min_nx  = r_ae_min;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (i_btn_mode) begin
                    w_state_nx   = S_EDIT_HOUR;
                    w_im_hour_nx = i_rtc_hour;
                    w_im_min_nx  = i_rtc_min;
                end
            end
            S_EDIT_HOUR: begin
                if (i_btn_mode) begin
                    w_state_nx = S_EDIT_MIN;
                end else if (w_tmo) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_im_hour_nx = f_step(r_im_hour, 8'd23, w_inc, w_dec);
                end
            end
            S_EDIT_MIN: begin
                if (i_btn_mode) begin
`ifdef RTC_TIME_SET_ALARM_EN
                    w_state_nx   = S_ALM_HOUR;
                    w_ae_hour_nx = r_alm_hour;
                    w_ae_min_nx  = r_alm_min;
`else
                    w_state_nx = S_COMMIT;
`endif
                end else if (w_tmo) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_im_min_nx = f_step(r_im_min, 8'd59, w_inc, w_dec);
                end
            end
`ifdef RTC_TIME_SET_ALARM_EN
            S_ALM_HOUR: begin
                if (i_btn_mode) begin
                    w_state_nx = S_ALM_MIN;
                end else if (w_tmo) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_ae_hour_nx = f_step(r_ae_hour, 8'd23, w_inc, w_dec);
                end
            end
            S_ALM_MIN: begin
                if (i_btn_mode) begin
                    w_state_nx = S_COMMIT;
                end else if (w_tmo) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_ae_min_nx = f_step(r_ae_min, 8'd59, w_inc, w_dec);
                end
            end
`endif
            S_COMMIT: begin
                if (r_cnt == MOD_LAST) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // One counter serves as edit timeout and as commit pulse length.
    assign w_clr = (w_state_nx != r_state) ||
                   (w_btn && r_state != S_COMMIT);

    always_comb begin
        w_cnt_nx = '0;
        if (!w_clr && r_state != S_IDLE) begin
            w_cnt_nx = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_modify  <= 1'b0;
            r_busy    <= 1'b0;
            r_im_hour <= 8'd0;
            r_im_min  <= 8'd0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_modify  <= (w_state_nx == S_COMMIT);
            r_busy    <= (w_state_nx != S_IDLE);
            r_im_hour <= w_im_hour_nx;
            r_im_min  <= w_im_min_nx;
        end
    end

`ifdef RTC_TIME_SET_ALARM_EN
    assign w_commit_entry = (w_state_nx == S_COMMIT) &&
                            (r_state != S_COMMIT);
    assign w_match = r_armed &&
                     (i_rtc_hour == r_alm_hour) &&
                     (i_rtc_min == r_alm_min) &&
                     (i_rtc_sec == 8'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ae_hour  <= 8'd0;
            r_ae_min   <= 8'd0;
            r_alm_hour <= 8'd0;
            r_alm_min  <= 8'd0;
            r_armed    <= 1'b0;
            r_match    <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_ae_hour <= w_ae_hour_nx;
            r_ae_min  <= w_ae_min_nx;
            if (w_commit_entry) begin
                r_alm_hour <= r_ae_hour;
                r_alm_min  <= r_ae_min;
                r_armed    <= 1'b1;
            end
            r_match <= w_match;
            r_alarm <= w_match & ~r_match;
        end
    end

    assign o_alarm = r_alarm;
`else
    logic w_unused_sec;
    assign w_unused_sec = ^i_rtc_sec;
    assign o_alarm      = 1'b0;
`endif

    assign o_state   = r_state;
    assign o_modify  = r_modify;
    assign o_busy    = r_busy;
    assign o_im_hour = r_im_hour;
    assign o_im_min  = r_im_min;

endmodule

// File: tb/tb_rtc_time_set_ctrl.sv
// Bench for rtc_time_set_ctrl: vector table through a scoreboard queue,
// plus a reset-during-commit sequence.
module tb_rtc_time_set_ctrl;

    localparam int TMO  = 50;
    localparam int MODC = 4;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_btn_mode, i_btn_up, i_btn_down;
    logic [7:0] i_rtc_sec, i_rtc_min, i_rtc_hour;
    logic       o_modify, o_busy, o_alarm;
    logic [7:0] o_im_min, o_im_hour;
    logic [2:0] o_state;

    always #5 clk = ~clk;

    rtc_time_set_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .MODIFY_CYCLES (MODC)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_btn_mode(i_btn_mode),
        .i_btn_up  (i_btn_up),
        .i_btn_down(i_btn_down),
        .i_rtc_sec (i_rtc_sec),
        .i_rtc_min (i_rtc_min),
        .i_rtc_hour(i_rtc_hour),
        .o_modify  (o_modify),
        .o_im_min  (o_im_min),
        .o_im_hour (o_im_hour),
        .o_state   (o_state),
        .o_busy    (o_busy),
        .o_alarm   (o_alarm)
    );

    typedef struct {
        logic       m, u, d;
        logic [7:0] rh, rm, rs;
        logic [2:0] st;
        logic [7:0] h, mi;
        logic       mod;
        logic       alm;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic m, input logic u, input logic d,
        input int rh, input int rm, input int rs,
        input int st, input int h, input int mi,
        input logic mod, input logic alm, input string nm
    );
        vec_t v;
        v.m = m; v.u = u; v.d = d;
        v.rh = 8'(rh); v.rm = 8'(rm); v.rs = 8'(rs);
        v.st = 3'(st); v.h = 8'(h); v.mi = 8'(mi);
        v.mod = mod; v.alm = alm; v.name = nm;
        return v;
    endfunction

    task automatic add(
        input logic m, input logic u, input logic d,
        input int rh, input int rm, input int rs,
        input int st, input int h, input int mi,
        input logic mod, input logic alm, input string nm
    );
        vecs.push_back(mk(m, u, d, rh, rm, rs, st, h, mi, mod, alm, nm));
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        i_btn_mode = v.m;
        i_btn_up   = v.u;
        i_btn_down = v.d;
        i_rtc_hour = v.rh;
        i_rtc_min  = v.rm;
        i_rtc_sec  = v.rs;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.name, ".state"}, 32'(o_state), 32'(e.st));
        chk({e.name, ".hour"}, 32'(o_im_hour), 32'(e.h));
        chk({e.name, ".min"}, 32'(o_im_min), 32'(e.mi));
        chk({e.name, ".modify"}, 32'(o_modify), 32'(e.mod));
        chk({e.name, ".busy"}, 32'(o_busy), 32'(e.st != 3'd0));
        chk({e.name, ".alarm"}, 32'(o_alarm), 32'(e.alm));
        i_btn_mode = 1'b0;
        i_btn_up   = 1'b0;
        i_btn_down = 1'b0;
    endtask

    initial begin
        // Basic set from 10:20: hour +3, minute -25 -> 13:55.
        add(1,0,0, 10,20,5, 1,10,20, 0,0, "enter");
        for (int k = 1; k <= 3; k++)
            add(0,1,0, 10,20,5, 1,10+k,20, 0,0, "hr_up");
        add(1,0,0, 10,20,5, 2,13,20, 0,0, "to_min");
        for (int k = 1; k <= 25; k++)
            add(0,0,1, 10,20,5, 2,13,(20-k+60)%60, 0,0, "min_dn");
`ifdef RTC_TIME_SET_ALARM_EN
        add(1,0,0, 10,20,5, 3,13,55, 0,0, "to_ah");
        add(1,0,0, 10,20,5, 4,13,55, 0,0, "to_am");
`endif
        add(1,0,0, 10,20,5, 5,13,55, 1,0, "commit1");
        add(0,1,0, 10,20,5, 5,13,55, 1,0, "commit2");
        add(0,0,1, 10,20,5, 5,13,55, 1,0, "commit3");
        add(1,0,0, 10,20,5, 5,13,55, 1,0, "commit4");
        add(0,0,0, 10,20,5, 0,13,55, 0,0, "done");
        add(0,1,1, 10,20,5, 0,13,55, 0,0, "idle_btn");
        // Wrap, priority and timeout from 23:00.
        add(1,0,0, 23,0,5, 1,23,0, 0,0, "load2");
        add(0,1,0, 23,0,5, 1,0,0, 0,0, "hr_wrap_up");
        add(0,0,1, 23,0,5, 1,23,0, 0,0, "hr_wrap_dn");
        add(0,1,1, 23,0,5, 1,23,0, 0,0, "hr_updn");
        add(1,1,0, 23,0,5, 2,23,0, 0,0, "mode_pri");
        add(0,0,1, 23,0,5, 2,23,59, 0,0, "min_wrap_dn");
        add(0,1,0, 23,0,5, 2,23,0, 0,0, "min_wrap_up");
        add(0,1,1, 23,0,5, 2,23,0, 0,0, "min_updn");
        for (int k = 1; k < TMO; k++)
            add(0,0,0, 23,0,5, 2,23,0, 0,0, "tmo_wait");
        add(0,0,0, 23,0,5, 0,23,0, 0,0, "tmo_idle");
        add(0,0,0, 23,0,5, 0,23,0, 0,0, "tmo_stay");
`ifdef RTC_TIME_SET_ALARM_EN
        // Set alarm 07:30 then cross it.
        add(1,0,0, 7,29,5, 1,7,29, 0,0, "a_enter");
        add(1,0,0, 7,29,5, 2,7,29, 0,0, "a_em");
        add(1,0,0, 7,29,5, 3,7,29, 0,0, "a_ah");
        for (int k = 1; k <= 7; k++)
            add(0,1,0, 7,29,5, 3,7,29, 0,0, "a_hr_up");
        add(1,0,0, 7,29,5, 4,7,29, 0,0, "a_am");
        for (int k = 1; k <= 30; k++)
            add(0,0,1, 7,29,5, 4,7,29, 0,0, "a_min_dn");
        add(1,0,0, 7,29,5, 5,7,29, 1,0, "a_commit");
        for (int k = 1; k < MODC; k++)
            add(0,0,0, 7,29,5, 5,7,29, 1,0, "a_commit_n");
        add(0,0,0, 7,29,59, 0,7,29, 0,0, "a_pre");
        add(0,0,0, 7,30,0, 0,7,29, 0,1, "a_hit");
        for (int k = 1; k <= 4; k++)
            add(0,0,0, 7,30,0, 0,7,29, 0,0, "a_hold");
        add(0,0,0, 7,30,1, 0,7,29, 0,0, "a_next_sec");
`endif

        i_reset    = 1'b1;
        i_btn_mode = 1'b0;
        i_btn_up   = 1'b0;
        i_btn_down = 1'b0;
        i_rtc_sec  = 8'd5;
        i_rtc_min  = 8'd20;
        i_rtc_hour = 8'd10;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state", 32'(o_state), 32'd0);
        chk("rst.modify", 32'(o_modify), 32'd0);
        chk("rst.hour", 32'(o_im_hour), 32'd0);
        chk("rst.min", 32'(o_im_min), 32'd0);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.alarm", 32'(o_alarm), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset in the second COMMIT cycle.
        apply(mk(1,0,0, 5,7,5, 1,5,7, 0,0, "r_enter"));
        apply(mk(1,0,0, 5,7,5, 2,5,7, 0,0, "r_em"));
`ifdef RTC_TIME_SET_ALARM_EN
        apply(mk(1,0,0, 5,7,5, 3,5,7, 0,0, "r_ah"));
        apply(mk(1,0,0, 5,7,5, 4,5,7, 0,0, "r_am"));
`endif
        apply(mk(1,0,0, 5,7,5, 5,5,7, 1,0, "r_commit"));
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid.state", 32'(o_state), 32'd0);
        chk("rmid.modify", 32'(o_modify), 32'd0);
        chk("rmid.hour", 32'(o_im_hour), 32'd0);
        chk("rmid.min", 32'(o_im_min), 32'd0);
        chk("rmid.busy", 32'(o_busy), 32'd0);
        chk("rmid.alarm", 32'(o_alarm), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        apply(mk(0,0,0, 5,7,5, 0,0,0, 0,0, "r_after"));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
